seg7_scan_driver: RTL and testbench

Multiplexed multi-digit 7-segment display driver, the parametrised successor to the single-digit BCD segment decoder. It time-multiplexes `DIGITS` digits onto one shared segment bus. Features:
- optional hex glyphs
- per-digit blanking and decimal points
- leading-zero suppression
- frame-synchronous double-buffered load, so the display never shows a torn value

It sits between the ALU result/BCD conversion logic and the board's segment and digit-enable pins.

---
 rtl/seg7_scan_driver.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed DIGITS-digit 7-segment driver with glyph decode, blanking, dp, leading-zero suppression.
// Latency : seg/seg_dp/dig are registered one cycle behind idx/pcnt; frame_done pulses the cycle after a frame boundary.
// Backpr. : none; loads are staged and committed only at a frame boundary, so a frame never mixes two loads.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 2,
  parameter bit HEX_EN         = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   stg_data, shd_data;
  logic [DIGITS-1:0]     stg_dp, shd_dp;
  logic [DIGITS-1:0]     stg_blank, shd_blank;
  logic                  stg_lz, shd_lz;
  logic                  pend;

  logic                  slot_end;
  logic                  last_dig;
  logic                  boundary;

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_lzs;
  logic                  zero_run;
  logic [7:0]            cur_glyph;
  logic                  in_window;
  logic [DIGITS-1:0]     dig_on;
  logic [6:0]            nxt_seg;
  logic                  nxt_dp;
  logic [DIGITS-1:0]     nxt_dig;

  // Glyph lookup: bit 7 = code is displayable, bits 6..0 = active-low segments a..g.
  function automatic logic [7:0] glyph(input logic [3:0] code);
    logic [7:0] g;
    case (code)
      4'h0: g = {1'b1, 7'b0000001};
      4'h1: g = {1'b1, 7'b1001111};
      4'h2: g = {1'b1, 7'b0010010};
      4'h3: g = {1'b1, 7'b0000110};
      4'h4: g = {1'b1, 7'b1001100};
      4'h5: g = {1'b1, 7'b0100100};
      4'h6: g = {1'b1, 7'b0100000};
      4'h7: g = {1'b1, 7'b0001111};
      4'h8: g = {1'b1, 7'b0000000};
      4'h9: g = {1'b1, 7'b0000100};
      4'hA: g = {HEX_EN, 7'b0001000};
      4'hB: g = {HEX_EN, 7'b1100000};
      4'hC: g = {HEX_EN, 7'b0110001};
      4'hD: g = {HEX_EN, 7'b1000010};
      4'hE: g = {HEX_EN, 7'b0110000};
      default: g = {HEX_EN, 7'b0111000};
    endcase
    return g;
  endfunction

  assign slot_end = (pcnt == PW'(CLK_DIV - 1));
  assign last_dig = (idx == IW'(DIGITS - 1));
  assign boundary = en & slot_end & last_dig;

  // Scan counters: prescaler steps every enabled cycle, digit index steps on prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (en) begin
      if (slot_end) begin
        pcnt <= '0;
        idx  <= last_dig ? '0 : idx + IW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Staging capture on load; pend marks data waiting for the next frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data  <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      stg_lz    <= 1'b0;
      pend      <= 1'b0;
    end else begin
      if (load) begin
        stg_data  <= data;
        stg_dp    <= dp;
        stg_blank <= blank;
        stg_lz    <= lz_en;
      end
      if (boundary)
        pend <= 1'b0;
      else if (load)
        pend <= 1'b1;
    end
  end

  // Shadow commit at the frame boundary; a load in the boundary cycle bypasses staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data  <= '0;
      shd_dp    <= '0;
      shd_blank <= '0;
      shd_lz    <= 1'b0;
    end else if (boundary && load) begin
      shd_data  <= data;
      shd_dp    <= dp;
      shd_blank <= blank;
      shd_lz    <= lz_en;
    end else if (boundary && pend) begin
      shd_data  <= stg_data;
      shd_dp    <= stg_dp;
      shd_blank <= stg_blank;
      shd_lz    <= stg_lz;
    end
  end

  // Select the current digit's fields and track whether it sits inside the leading-zero run.
  always_comb begin
    cur_code  = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lzs   = 1'b0;
    zero_run  = 1'b1;
    dig_on    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shd_data[4*i +: 4] == 4'd0);
      dig_on[i] = (idx == IW'(i));
      if (idx == IW'(i)) begin
        cur_code  = shd_data[4*i +: 4];
        cur_dp    = shd_dp[i];
        cur_blank = shd_blank[i];
        cur_lzs   = shd_lz & (i > 0) & zero_run;
      end
    end
  end

  // Anti-ghosting window: the digit enable is withheld for the first BLANK_CYC cycles of a slot.
  generate
    if (BLANK_CYC == 0) begin : g_nowin
      assign in_window = 1'b1;
    end else begin : g_win
      assign in_window = (pcnt >= PW'(BLANK_CYC));
    end
  endgenerate

  assign cur_glyph = glyph(cur_code);

  // Next output values: suppression forces segments off, blanking also kills the dp.
  always_comb begin
    nxt_seg = cur_glyph[6:0];
    if (cur_blank || !cur_glyph[7] || cur_lzs)
      nxt_seg = SEG_OFF;
    nxt_dp  = cur_blank ? 1'b1 : ~cur_dp;
    nxt_dig = in_window ? (DIG_OFF ^ dig_on) : DIG_OFF;
  end

  // Output registers; scan disabled parks every pin in its off state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      seg_dp     <= 1'b1;
      dig        <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (en) begin
        seg    <= nxt_seg;
        seg_dp <= nxt_dp;
        dig    <= nxt_dig;
      end else begin
        seg    <= SEG_OFF;
        seg_dp <= 1'b1;
        dig    <= DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus pushes the expected per-digit frame, a monitor pops one entry
// at the first active cycle of each digit slot. Two instances share inputs: HEX_EN=0 and HEX_EN=1.
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06, G4 = 7'h4C, G5 = 7'h24;
  localparam logic [6:0] GA = 7'h08, GB = 7'h60, GC = 7'h31, GF = 7'h38, OFF = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n, en, load, lz_en;
  logic [15:0] data;
  logic [3:0]  dp, blank;
  logic [6:0]  seg0, seg1;
  logic        sdp0, sdp1, fd0, fd1;
  logic [3:0]  dig0, dig1;

  typedef struct packed {
    logic [1:0] d;
    logic [6:0] s;
    logic       p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nvec = 0;
  int   nerr = 0;
  logic pa0 = 1'b0;
  logic pa1 = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_EN(1'b0), .DIG_ACTIVE_LOW(1'b1)) u_dec (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp(dp), .blank(blank),
    .lz_en(lz_en), .seg(seg0), .seg_dp(sdp0), .dig(dig0), .frame_done(fd0));

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .HEX_EN(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp(dp), .blank(blank),
    .lz_en(lz_en), .seg(seg1), .seg_dp(sdp1), .dig(dig1), .frame_done(fd1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare at the first active cycle of every digit slot while expectations are queued.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ed;
    if (dig0 !== 4'hF && !pa0 && q0.size() > 0) begin
      e  = q0.pop_front();
      ed = ~(4'b0001 << e.d);
      chk($sformatf("dec_dig%0d_seg", e.d), {25'd0, seg0}, {25'd0, e.s});
      chk($sformatf("dec_dig%0d_dp", e.d), {31'd0, sdp0}, {31'd0, e.p});
      chk($sformatf("dec_dig%0d_en", e.d), {28'd0, dig0}, {28'd0, ed});
    end
    if (dig1 !== 4'hF && !pa1 && q1.size() > 0) begin
      e  = q1.pop_front();
      ed = ~(4'b0001 << e.d);
      chk($sformatf("hex_dig%0d_seg", e.d), {25'd0, seg1}, {25'd0, e.s});
      chk($sformatf("hex_dig%0d_dp", e.d), {31'd0, sdp1}, {31'd0, e.p});
      chk($sformatf("hex_dig%0d_en", e.d), {28'd0, dig1}, {28'd0, ed});
    end
    pa0 = (dig0 !== 4'hF);
    pa1 = (dig1 !== 4'hF);
  end

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd0 && n < 100);
    if (!fd0) begin
      nvec++;
      nerr++;
      $display("FAIL frame_done_timeout: none within %0d cycles, expected a pulse", n);
    end
  endtask

  // s0/s1 are {digit3, digit2, digit1, digit0} glyphs; p is the expected seg_dp per digit.
  task automatic push(input logic [27:0] s0, input logic [27:0] s1, input logic [3:0] p);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.d = 2'(d);
      e.p = p[d];
      e.s = s0[7*d +: 7];
      q0.push_back(e);
      e.s = s1[7*d +: 7];
      q1.push_back(e);
    end
  endtask

  task automatic load_v(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk, input logic lz);
    data  = d;
    dp    = dpv;
    blank = blk;
    lz_en = lz;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk, input logic lz,
                       input logic [27:0] s0, input logic [27:0] s1, input logic [3:0] p);
    int n;
    load_v(d, dpv, blk, lz);
    wait_fd(n);
    push(s0, s1, p);
    wait_fd(n);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; dp = '0; blank = '0; lz_en = 1'b0;
    #12;
    chk("rst_seg", {25'd0, seg0}, {25'd0, OFF});
    chk("rst_dp", {31'd0, sdp0}, 32'd1);
    chk("rst_dig", {28'd0, dig0}, 32'hF);
    chk("rst_fd", {31'd0, fd0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First active digit appears BLANK_CYC+1 = 2 enabled edges after scan starts, on digit 0.
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig0 === 4'hF && n < 20);
    chk("first_dig_latency", n, 32'd2);
    chk("first_dig_value", {28'd0, dig0}, 32'hE);

    frame(16'h1234, 4'h0, 4'h0, 1'b0, {G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'hF);
    wait_fd(n);
    chk("frame_period", n, 32'd16);

    frame(16'h0050, 4'h0, 4'h0, 1'b1, {OFF, OFF, G5, G0}, {OFF, OFF, G5, G0}, 4'hF);
    frame(16'h0000, 4'h0, 4'h0, 1'b1, {OFF, OFF, OFF, G0}, {OFF, OFF, OFF, G0}, 4'hF);
    frame(16'hABCF, 4'h0, 4'h0, 1'b0, {OFF, OFF, OFF, OFF}, {GA, GB, GC, GF}, 4'hF);
    frame(16'h1234, 4'b0100, 4'b0001, 1'b0, {G1, G2, G3, OFF}, {G1, G2, G3, OFF}, 4'b1011);

    // Two loads inside one frame: the later one wins and the whole frame shows it.
    load_v(16'h1111, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    load_v(16'h2222, 4'h0, 4'h0, 1'b0);
    wait_fd(n);
    push({G2, G2, G2, G2}, {G2, G2, G2, G2}, 4'hF);
    wait_fd(n);

    // Scan disable for 10 cycles: outputs park off and the frame completes 10 cycles late.
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_dig", {28'd0, dig0}, 32'hF);
    chk("dis_seg", {25'd0, seg0}, {25'd0, OFF});
    chk("dis_dp", {31'd0, sdp0}, 32'd1);
    repeat (8) @(negedge clk);
    en = 1'b1;
    wait_fd(n);
    chk("resume_to_frame", n, 32'd11);

    // Asynchronous reset mid-frame with a load still pending: the pending data is discarded.
    load_v(16'h5678, 4'hF, 4'h0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", {25'd0, seg0}, {25'd0, OFF});
    chk("arst_dp", {31'd0, sdp0}, 32'd1);
    chk("arst_dig", {28'd0, dig0}, 32'hF);
    chk("arst_fd", {31'd0, fd0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fd(n);
    push({G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'hF);
    wait_fd(n);

    chk("queue_drained", q0.size() + q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
